// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: mode sequencer for the 4-LED bank.
//
// Runs one of four display patterns and advances it once per step period.
// Mode requests come from the key debouncer (key_flag) and the RS485 receive
// path (rx_flag/rx_data). If both arrive in the same cycle, the rx command is
// applied and the key advance is held for one cycle. LEDs are active-low.
//
// Ports:
//   sys_clk    in   system clock (50 MHz)
//   sys_rst_n  in   asynchronous reset, active-low
//   key_flag   in   one-cycle pulse, advance to the next mode
//   rx_flag    in   one-cycle pulse, rx_data valid
//   rx_data    in   [7:0] command byte (8'h00..8'h03 select a mode)
//   mode       out  [1:0] current mode
//   led_out    out  [3:0] LED drive, active-low
//
// Optional build macro: LED_SPEED_CTRL_EN
//   Adds a 2-bit speed register. rx_data 8'h20..8'h23 shortens the step
//   period to (CNT_MAX >> speed) + 1 cycles.
//
// state | meaning
// ------+---------------------------------------------
//   0   | WATER      : one lit LED, shifted left per step
//   1   | WATER_REV  : one lit LED, shifted right per step
//   2   | BLINK      : all LEDs toggle per step
//   3   | OFF        : all LEDs dark
module led_mode_ctrl #(
   parameter logic [24:0] CNT_MAX = 25'd24_999_999
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       key_flag,
   input  logic       rx_flag,
   input  logic [7:0] rx_data,
   output logic [1:0] mode,
   output logic [3:0] led_out
);

   localparam logic [1:0] ST_WATER     = 2'd0;
   localparam logic [1:0] ST_WATER_REV = 2'd1;
   localparam logic [1:0] ST_BLINK     = 2'd2;
   localparam logic [1:0] ST_OFF       = 2'd3;

   logic [1:0]  r_mode;
   logic [3:0]  r_pattern;
   logic [24:0] r_cnt;
   logic        r_key_pending;

   logic [24:0] w_limit;
   logic        w_tick;
   logic        w_rx_mode;
   logic        w_rx_speed;
   logic        w_rx_cmd;
   logic        w_adv;
   logic        w_load;
   logic [1:0]  w_next_mode;

   function automatic logic [3:0] start_pattern(input logic [1:0] m);
      case (m)
         ST_WATER:     start_pattern = 4'b0001;
         ST_WATER_REV: start_pattern = 4'b1000;
         ST_BLINK:     start_pattern = 4'b1111;
         default:      start_pattern = 4'b0000;
      endcase
   endfunction

   function automatic logic [3:0] step_pattern(input logic [1:0] m, input logic [3:0] p);
      case (m)
         ST_WATER:     step_pattern = {p[2:0], p[3]};
         ST_WATER_REV: step_pattern = {p[0], p[3:1]};
         ST_BLINK:     step_pattern = ~p;
         default:      step_pattern = 4'b0000;
      endcase
   endfunction

`ifdef LED_SPEED_CTRL_EN
   logic [1:0] r_speed;

   assign w_limit    = CNT_MAX >> r_speed;
   assign w_rx_speed = rx_flag && (rx_data[7:2] == 6'b001000);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_speed <= 2'd0;
      end else if (w_rx_speed) begin
         r_speed <= rx_data[1:0];
      end
   end
`else
   assign w_limit    = CNT_MAX;
   assign w_rx_speed = 1'b0;
`endif

   assign w_tick    = (r_cnt == w_limit);
   assign w_rx_mode = rx_flag && (rx_data[7:2] == 6'd0);
   assign w_rx_cmd  = w_rx_mode | w_rx_speed;

   // A held key request and a fresh key_flag collapse into a single advance.
   assign w_adv       = (key_flag | r_key_pending) & ~w_rx_cmd;
   assign w_load      = w_rx_mode | w_adv;
   assign w_next_mode = w_rx_mode ? rx_data[1:0] : r_mode + 2'd1;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_mode        <= ST_WATER;
         r_pattern     <= 4'b0001;
         r_cnt         <= '0;
         r_key_pending <= 1'b0;
      end else begin
         // Pending stays one-deep: it survives back-to-back rx commands and
         // is consumed by the first cycle without one.
         r_key_pending <= w_rx_cmd ? (r_key_pending | key_flag) : 1'b0;

         // A mode load wins over a coincident tick, so no shift is applied.
         if (w_load) begin
            r_mode    <= w_next_mode;
            r_pattern <= start_pattern(w_next_mode);
            r_cnt     <= '0;
         end else if (w_rx_speed) begin
            r_cnt     <= '0;
         end else if (w_tick) begin
            r_pattern <= step_pattern(r_mode, r_pattern);
            r_cnt     <= '0;
         end else begin
            r_cnt     <= r_cnt + 25'd1;
         end
      end
   end

   assign mode    = r_mode;
   assign led_out = ~r_pattern;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: self-checking bench for led_mode_ctrl with CNT_MAX = 9
// (one step every 10 clocks). Expected mode/led_out values are pushed to a
// scoreboard queue as each cycle's stimulus is driven and popped after the
// active edge. Builds with or without LED_SPEED_CTRL_EN.
module tb_led_mode_ctrl;

   logic       sys_clk;
   logic       sys_rst_n;
   logic       key_flag;
   logic       rx_flag;
   logic [7:0] rx_data;
   logic [1:0] mode;
   logic [3:0] led_out;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int         gap;
      bit         key;
      bit         rxf;
      logic [7:0] rxd;
      logic [1:0] mode;
      logic [3:0] led;
   } vec_t;

   typedef struct {
      string      tag;
      logic [1:0] mode;
      logic [3:0] led;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   logic [3:0] led_seq [5];

   led_mode_ctrl #(.CNT_MAX(25'd9)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_flag  (key_flag),
      .rx_flag   (rx_flag),
      .rx_data   (rx_data),
      .mode      (mode),
      .led_out   (led_out)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input bit k, input bit rf, input logic [7:0] rd,
                      input logic [1:0] em, input logic [3:0] el, input string tag);
      exp_t e;
      key_flag = k;
      rx_flag  = rf;
      rx_data  = rd;
      sb.push_back('{tag, em, el});
      @(posedge sys_clk);
      #1;
      key_flag = 1'b0;
      rx_flag  = 1'b0;
      rx_data  = 8'h00;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty, got none, expected 1 entry", tag);
      end else begin
         n_checks--;
         e = sb.pop_front();
         chk({e.tag, ".mode"}, {2'b00, mode}, {2'b00, e.mode});
         chk({e.tag, ".led"}, led_out, e.led);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic do_reset(input string tag);
      key_flag  = 1'b0;
      rx_flag   = 1'b0;
      rx_data   = 8'h00;
      sys_rst_n = 1'b0;
      #3;
      chk({tag, ".rst_mode"}, {2'b00, mode}, 4'b0000);
      chk({tag, ".rst_led"}, led_out, 4'b1110);
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
   endtask

   initial begin
      led_seq[0] = 4'b1110;
      led_seq[1] = 4'b1101;
      led_seq[2] = 4'b1011;
      led_seq[3] = 4'b0111;
      led_seq[4] = 4'b1110;

      // gap = unchecked idle cycles before the checked cycle
      tbl.push_back('{0, 1'b1, 1'b0, 8'h00, 2'd1, 4'b0111}); // key -> WATER_REV
      tbl.push_back('{2, 1'b1, 1'b0, 8'h00, 2'd2, 4'b0000}); // key -> BLINK
      tbl.push_back('{8, 1'b0, 1'b0, 8'h00, 2'd2, 4'b0000}); // cnt=9, no tick yet
      tbl.push_back('{0, 1'b0, 1'b0, 8'h00, 2'd2, 4'b1111}); // tick: toggle
      tbl.push_back('{9, 1'b0, 1'b0, 8'h00, 2'd2, 4'b0000}); // toggle back
      tbl.push_back('{2, 1'b1, 1'b0, 8'h00, 2'd3, 4'b1111}); // key -> OFF
      tbl.push_back('{15, 1'b0, 1'b0, 8'h00, 2'd3, 4'b1111}); // OFF holds
      tbl.push_back('{0, 1'b1, 1'b0, 8'h00, 2'd0, 4'b1110}); // wrap 3 -> 0
      tbl.push_back('{9, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1101}); // first shift
      tbl.push_back('{0, 1'b1, 1'b1, 8'h01, 2'd1, 4'b0111}); // rx wins, key pending
      tbl.push_back('{0, 1'b0, 1'b0, 8'h00, 2'd2, 4'b0000}); // pending applied
      tbl.push_back('{0, 1'b0, 1'b0, 8'h00, 2'd2, 4'b0000}); // no second advance
      tbl.push_back('{0, 1'b1, 1'b1, 8'h00, 2'd0, 4'b1110}); // rx wins, pending
      tbl.push_back('{0, 1'b1, 1'b1, 8'h03, 2'd3, 4'b1111}); // rx again, key merged
      tbl.push_back('{0, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1110}); // single advance 3 -> 0
      tbl.push_back('{0, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1110}); // nothing queued
      tbl.push_back('{0, 1'b1, 1'b1, 8'h01, 2'd1, 4'b0111}); // pending set
      tbl.push_back('{0, 1'b1, 1'b0, 8'h00, 2'd2, 4'b0000}); // key + pending merge
      tbl.push_back('{0, 1'b0, 1'b0, 8'h00, 2'd2, 4'b0000}); // still one advance
      tbl.push_back('{0, 1'b0, 1'b1, 8'h00, 2'd0, 4'b1110}); // rx select WATER
      tbl.push_back('{3, 1'b0, 1'b1, 8'h55, 2'd0, 4'b1110}); // invalid byte ignored
      tbl.push_back('{4, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1110}); // cnt=9 after 8'h55
      tbl.push_back('{0, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1101}); // original tick kept
      tbl.push_back('{0, 1'b0, 1'b1, 8'h00, 2'd0, 4'b1110}); // same-mode restart
      tbl.push_back('{9, 1'b1, 1'b0, 8'h00, 2'd1, 4'b0111}); // key on tick: no shift
      tbl.push_back('{9, 1'b0, 1'b0, 8'h00, 2'd1, 4'b1011}); // shift right
      tbl.push_back('{9, 1'b0, 1'b1, 8'h02, 2'd2, 4'b0000}); // rx on tick
      tbl.push_back('{0, 1'b0, 1'b0, 8'h00, 2'd2, 4'b0000});
      tbl.push_back('{0, 1'b1, 1'b1, 8'h04, 2'd3, 4'b1111}); // invalid rx, key wins

      sys_rst_n = 1'b0;
      key_flag  = 1'b0;
      rx_flag   = 1'b0;
      rx_data   = 8'h00;
      #12;

      // Free-running WATER sequence after reset
      do_reset("run");
      for (int t = 1; t <= 40; t++) begin
         cyc(1'b0, 1'b0, 8'h00, 2'd0, led_seq[t / 10], $sformatf("run%0d", t));
      end

      // Mode request table
      do_reset("tbl");
      for (int i = 0; i < tbl.size(); i++) begin
         idle(tbl[i].gap);
         cyc(tbl[i].key, tbl[i].rxf, tbl[i].rxd, tbl[i].mode, tbl[i].led,
             $sformatf("vec%0d", i));
      end

      // Reset mid-step with a key request pending
      do_reset("arst");
      cyc(1'b1, 1'b1, 8'h01, 2'd1, 4'b0111, "arst_set");
      #2;
      sys_rst_n = 1'b0;
      #1;
      chk("arst_now_mode", {2'b00, mode}, 4'b0000);
      chk("arst_now_led", led_out, 4'b1110);
      @(posedge sys_clk);
      #1;
      chk("arst_hold_led", led_out, 4'b1110);
      sys_rst_n = 1'b1;
      for (int t = 1; t <= 10; t++) begin
         cyc(1'b0, 1'b0, 8'h00, 2'd0, led_seq[t / 10], $sformatf("arst_rel%0d", t));
      end

      // Speed command byte
      do_reset("spd");
      cyc(1'b0, 1'b1, 8'h22, 2'd0, 4'b1110, "spd_cmd");
      for (int t = 2; t <= 11; t++) begin
`ifdef LED_SPEED_CTRL_EN
         cyc(1'b0, 1'b0, 8'h00, 2'd0, led_seq[(t - 1) / 3], $sformatf("spd%0d", t));
`else
         cyc(1'b0, 1'b0, 8'h00, 2'd0, led_seq[t / 10], $sformatf("spd%0d", t));
`endif
      end
`ifdef LED_SPEED_CTRL_EN
      cyc(1'b1, 1'b1, 8'h20, 2'd0, 4'b0111, "spd_key_rx");
      cyc(1'b0, 1'b0, 8'h00, 2'd1, 4'b0111, "spd_key_pend");
      for (int t = 1; t <= 10; t++) begin
         cyc(1'b0, 1'b0, 8'h00, 2'd1, (t == 10) ? 4'b1011 : 4'b0111,
             $sformatf("spd_full%0d", t));
      end
`endif

      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
